// File: rtl/control_address_sequencer.sv
// Microprogram sequencer: owns the control address register and fetches microwords over a req/ack handshake.
// Optional CAR_SUBROUTINE_EN builds a one-entry subroutine return register (SBR) for call/ret.
module control_address_sequencer #(
  parameter int          ADDR_W     = 8,
  parameter int          OPC_W      = 4,
  parameter int unsigned RESET_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              halt_req,
  input  logic              mem_ack,
  input  logic              output_lgate,
  input  logic              BS1,
  input  logic              BS0,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic [OPC_W-1:0]  opcode,
  input  logic              call,
  input  logic              ret,
  output logic [ADDR_W-1:0] car,
  output logic              car_req,
  output logic              uword_valid,
  output logic              busy
);

  // state | meaning
  // IDLE  | waiting for start after reset
  // FETCH | car_req high, waiting for mem_ack
  // EXEC  | microword valid for one cycle; car updated at its closing edge
  // HALT  | car frozen, waiting for start
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] car_q, car_d;
  logic [ADDR_W-1:0] car_inc;
  logic [ADDR_W-1:0] map_addr;

  assign car_inc  = car_q + ADDR_W'(1);
  assign map_addr = {{(ADDR_W-OPC_W){1'b0}}, opcode} << 2;

`ifdef CAR_SUBROUTINE_EN
  logic [ADDR_W-1:0] sbr_q, sbr_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sbr_q <= '0;
    else          sbr_q <= sbr_d;
  end
`else
  logic unused_subroutine;
  assign unused_subroutine = &{1'b0, call, ret};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      car_q   <= ADDR_W'(RESET_ADDR);
    end else begin
      state_q <= state_d;
      car_q   <= car_d;
    end
  end

  always_comb begin
    state_d = state_q;
    car_d   = car_q;
`ifdef CAR_SUBROUTINE_EN
    sbr_d   = sbr_q;
`endif
    case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: if (mem_ack) state_d = S_EXEC;
      S_EXEC: begin
        state_d = halt_req ? S_HALT : S_FETCH;
`ifdef CAR_SUBROUTINE_EN
        if (call && output_lgate && !ret) sbr_d = car_inc;
        if (ret)                                     car_d = sbr_q;
        else if (output_lgate && BS1 && BS0)         car_d = map_addr;
        else if (output_lgate)                       car_d = branch_addr;
        else                                         car_d = car_inc;
`else
        if (output_lgate && BS1 && BS0)              car_d = map_addr;
        else if (output_lgate)                       car_d = branch_addr;
        else                                         car_d = car_inc;
`endif
      end
      S_HALT:  if (start) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode from state only: no input-to-output combinational path.
  assign car         = car_q;
  assign car_req     = (state_q == S_FETCH);
  assign uword_valid = (state_q == S_EXEC);
  assign busy        = (state_q == S_FETCH) || (state_q == S_EXEC);

endmodule

// File: tb/tb_control_address_sequencer.sv
// Directed bench for control_address_sequencer: vector table plus hand-written reset and subroutine sequences.
module tb_control_address_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, halt_req, mem_ack, output_lgate, BS1, BS0, call, ret;
  logic [7:0] branch_addr;
  logic [3:0] opcode;
  logic [7:0] car;
  logic       car_req, uword_valid, busy;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  control_address_sequencer #(.ADDR_W(8), .OPC_W(4), .RESET_ADDR(0)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .halt_req(halt_req),
    .mem_ack(mem_ack), .output_lgate(output_lgate), .BS1(BS1), .BS0(BS0),
    .branch_addr(branch_addr), .opcode(opcode), .call(call), .ret(ret),
    .car(car), .car_req(car_req), .uword_valid(uword_valid), .busy(busy)
  );

  typedef struct {
    logic       start, halt, ack, lgate;
    logic [1:0] bs;
    logic [7:0] br;
    logic [3:0] opc;
    logic [7:0] car;
    logic       req, uv, busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic s, logic h, logic a, logic l, logic [1:0] bs,
                              logic [7:0] br, logic [3:0] opc,
                              logic [7:0] c, logic rq, logic uv, logic bz);
    vec_t v;
    v.start = s; v.halt = h; v.ack = a; v.lgate = l; v.bs = bs; v.br = br; v.opc = opc;
    v.car = c; v.req = rq; v.uv = uv; v.busy = bz;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [7:0] c, input logic rq,
                            input logic uv, input logic bz);
    chk({tag, " car"}, 32'(car), 32'(c));
    chk({tag, " car_req"}, 32'(car_req), 32'(rq));
    chk({tag, " uword_valid"}, 32'(uword_valid), 32'(uv));
    chk({tag, " busy"}, 32'(busy), 32'(bz));
  endtask

  // Drive one cycle of inputs, clock once, check outputs just after the edge.
  task automatic step(input logic s, input logic h, input logic a, input logic l,
                      input logic [1:0] bs, input logic [7:0] br, input logic [3:0] opc,
                      input logic cl, input logic rt, input string tag,
                      input logic [7:0] c, input logic rq, input logic uv, input logic bz);
    start = s; halt_req = h; mem_ack = a; output_lgate = l;
    {BS1, BS0} = bs; branch_addr = br; opcode = opc; call = cl; ret = rt;
    @(posedge clk); #1;
    check_outs(tag, c, rq, uv, bz);
  endtask

  logic [7:0] exp_ret, exp_both;

  initial begin
    reset_n = 1'b0; start = 0; halt_req = 0; mem_ack = 0; output_lgate = 0;
    BS1 = 0; BS0 = 0; branch_addr = 0; opcode = 0; call = 0; ret = 0;

    //            st h  ak lg bs     br     opc    car    rq uv bz
    vecs.push_back(mk(1, 0, 0, 0, 2'b00, 8'h00, 4'h0, 8'h00, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 2'b00, 8'h00, 4'h0, 8'h00, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 2'b00, 8'h00, 4'h0, 8'h01, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 2'b00, 8'h00, 4'h0, 8'h01, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 2'b00, 8'h00, 4'h0, 8'h02, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 2'b00, 8'h00, 4'h0, 8'h02, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 2'b00, 8'h00, 4'h0, 8'h03, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 2'b00, 8'h00, 4'h0, 8'h03, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 2'b01, 8'h40, 4'h0, 8'h40, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 2'b00, 8'h00, 4'h0, 8'h40, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 2'b11, 8'h33, 4'hA, 8'h28, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 2'b00, 8'h00, 4'h0, 8'h28, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 2'b00, 8'hFF, 4'h0, 8'hFF, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 2'b00, 8'h00, 4'h0, 8'hFF, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 0, 2'b00, 8'h00, 4'h0, 8'h00, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 2'b00, 8'h00, 4'h0, 8'h00, 1, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 2'b00, 8'h00, 4'h0, 8'h00, 1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 1, 2'b01, 8'h55, 4'h0, 8'h00, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 2'b00, 8'h00, 4'h0, 8'h00, 0, 1, 1));
    vecs.push_back(mk(0, 0, 1, 1, 2'b10, 8'h07, 4'h0, 8'h07, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 2'b00, 8'h00, 4'h0, 8'h07, 0, 1, 1));
    vecs.push_back(mk(0, 1, 1, 0, 2'b00, 8'h00, 4'h0, 8'h08, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 2'b01, 8'h22, 4'h0, 8'h08, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 2'b00, 8'h00, 4'h0, 8'h08, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 2'b00, 8'h00, 4'h0, 8'h08, 0, 1, 1));
    vecs.push_back(mk(1, 0, 1, 0, 2'b00, 8'h00, 4'h0, 8'h09, 1, 0, 1));

    #12;
    check_outs("reset", 8'h00, 0, 0, 0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    check_outs("idle_hold", 8'h00, 0, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].start, vecs[i].halt, vecs[i].ack, vecs[i].lgate, vecs[i].bs,
           vecs[i].br, vecs[i].opc, 1'b0, 1'b0, $sformatf("vec%0d", i),
           vecs[i].car, vecs[i].req, vecs[i].uv, vecs[i].busy);
    end

    // Asynchronous reset mid-FETCH (car=9, car_req=1)
    start = 0; mem_ack = 0;
    #3 reset_n = 1'b0;
    #1 check_outs("async_rst", 8'h00, 0, 0, 0);
    @(negedge clk); reset_n = 1'b1;
    step(0, 0, 1, 0, 2'b00, 8'h00, 4'h0, 0, 0, "post_rst", 8'h00, 0, 0, 0);

    // Subroutine call / return
`ifdef CAR_SUBROUTINE_EN
    exp_ret  = 8'h11;
    exp_both = 8'h11;
`else
    exp_ret  = 8'h81;
    exp_both = 8'h50;
`endif
    step(1, 0, 0, 0, 2'b00, 8'h00, 4'h0, 0, 0, "sub_f0", 8'h00, 1, 0, 1);
    step(0, 0, 1, 0, 2'b00, 8'h00, 4'h0, 0, 0, "sub_e0", 8'h00, 0, 1, 1);
    step(0, 0, 1, 1, 2'b00, 8'h10, 4'h0, 0, 0, "sub_f10", 8'h10, 1, 0, 1);
    step(0, 0, 1, 0, 2'b00, 8'h00, 4'h0, 0, 0, "sub_e10", 8'h10, 0, 1, 1);
    step(0, 0, 1, 1, 2'b01, 8'h80, 4'h0, 1, 0, "call_f80", 8'h80, 1, 0, 1);
    step(0, 0, 1, 0, 2'b00, 8'h00, 4'h0, 0, 0, "call_e80", 8'h80, 0, 1, 1);
    step(0, 0, 1, 0, 2'b00, 8'h00, 4'h0, 0, 1, "ret", exp_ret, 1, 0, 1);
    step(0, 0, 1, 0, 2'b00, 8'h00, 4'h0, 0, 0, "ret_exec", exp_ret, 0, 1, 1);
    step(0, 0, 1, 1, 2'b01, 8'h50, 4'h0, 1, 1, "call_and_ret", exp_both, 1, 0, 1);
    step(0, 0, 1, 0, 2'b00, 8'h00, 4'h0, 0, 0, "car_exec", exp_both, 0, 1, 1);
    step(0, 0, 1, 0, 2'b00, 8'h00, 4'h0, 0, 1, "ret_again", 8'h11 & {8{exp_ret == 8'h11}} | (8'h51 & {8{exp_ret != 8'h11}}), 1, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
